// File: rtl/buffer_pkg.sv
// buffer_pkg: shared sizes and source encoding for the buffer controller
package buffer_pkg;
  localparam int DATA_W = 47;
  localparam int DEPTH = 4;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; priority flips to the loser on each grant taken
module rr_arb2
  import buffer_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       prio_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       prio_o
);
  // lone requester wins, otherwise prio picks; next prio favours the requester not granted
  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | (prio_i == SRC_A));
    gnt_o[1] = req_i[1] & (~req_i[0] | (prio_i == SRC_B));
    prio_o = advance_i ? (gnt_o[1] ? SRC_A : SRC_B) : prio_i;
  end
endmodule

// File: rtl/buffer_ctrl.sv
// buffer_ctrl: two-writer one-reader FIFO control around an external 4-entry register file
module buffer_ctrl
  import buffer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_a_valid,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_buf_wr_en,
  output logic [ADDR_W-1:0] o_buf_wr_addr,
  output logic [DATA_W-1:0] o_buf_wr_data,
  output logic [ADDR_W-1:0] o_buf_rd_addr,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_rd_src,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              prio_q, prio_d, prio_nxt;
  logic [DEPTH-1:0]  tag_q, tag_d;
  logic [1:0]        gnt;
  logic              full, empty, can_push, push, pop;
  assign full = count_q == (ADDR_W+1)'(DEPTH);
  assign empty = count_q == '0;
  // no acceptance while full, flushing or held in reset, so nothing is written then
  assign can_push = i_rst_n & ~full & ~i_flush;
  assign push = |gnt & can_push;
  assign pop = ~empty & i_rd_ready & ~i_flush;
  rr_arb2 u_arb (
    .req_i     ({i_b_valid, i_a_valid}),
    .prio_i    (prio_q),
    .advance_i (push),
    .gnt_o     (gnt),
    .prio_o    (prio_nxt)
  );
  // write side and read side decodes; the data mux defaults to A when idle
  always_comb begin
    o_a_ready = gnt[0] & can_push;
    o_b_ready = gnt[1] & can_push;
    o_buf_wr_en = push;
    o_buf_wr_addr = wr_ptr_q;
    o_buf_wr_data = o_b_ready ? i_b_data : i_a_data;
    o_buf_rd_addr = rd_ptr_q;
    o_rd_valid = ~empty;
    o_rd_src = tag_q[rd_ptr_q];
    o_count = count_q;
    o_full = full;
    o_empty = empty;
  end
  // next state: flush clears pointers, count and priority but leaves the tags alone
  always_comb begin
    wr_ptr_d = i_flush ? '0 : wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = i_flush ? '0 : rd_ptr_q + ADDR_W'(pop);
    count_d = i_flush ? '0 : count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    prio_d = i_flush ? SRC_A : prio_nxt;
    tag_d = tag_q;
    if (push) tag_d[wr_ptr_q] = o_b_ready;
  end
  // state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      prio_q <= SRC_A;
      tag_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      prio_q <= prio_d;
      tag_q <= tag_d;
    end
  end
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(pop && empty));
  a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n) count_q <= (ADDR_W+1)'(DEPTH));
endmodule

// File: doc/buffer_ctrl.md
# buffer_ctrl

Controller that turns the 4-entry, 47-bit buffer register file into a two-writer, one-reader FIFO. It arbitrates two upstream write requesters round-robin and generates the buffer's write address, write enable and write data. It generates the buffer's read address and presents a valid/ready interface to the single downstream consumer. The consumer takes read data directly from the buffer's combinational read port; this block supplies only addressing, flow control and a per-entry source tag.

## Interface

- DATA_W, 47, entry width; must equal the buffer width.
- DEPTH, 4, number of entries; power of two.
- ADDR_W, 2, log2(DEPTH).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous clear of all FIFO state.
- i_a_valid  in  1  requester A has a word.
- i_a_data  in  DATA_W  requester A word.
- o_a_ready  out  1  A's word is accepted this cycle.
- i_b_valid, i_b_data, o_b_ready  as for A.
- o_buf_wr_en  out  1  buffer write enable.
- o_buf_wr_addr  out  ADDR_W  buffer write address.
- o_buf_wr_data  out  DATA_W  buffer write data.
- o_buf_rd_addr  out  ADDR_W  buffer read address (head entry).
- o_rd_valid  out  1  head entry is valid.
- i_rd_ready  in  1  consumer pops the head.
- o_rd_src  out  1  source of the head entry (0 = A, 1 = B).
- o_count  out  ADDR_W+1  occupancy, 0..DEPTH.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.

## Operation

- State:
  - wr_ptr and rd_ptr, each ADDR_W bits, wrapping modulo DEPTH.
  - count, ADDR_W+1 bits.
  - prio: 1 bit, 0 = A preferred.
  - src_tag[DEPTH]: 1 bit per entry.
- Arbitration (combinational):
  - If exactly one of A/B is valid, that requester wins.
  - If both are valid, the requester selected by prio wins.
  - o_x_ready = win_x && !o_full && !i_flush. At most one ready is high per cycle.
  - The loser's ready stays low, and its valid/data must be held.
- Push (valid && ready on A or B):
  - o_buf_wr_en = 1, o_buf_wr_addr = wr_ptr, o_buf_wr_data = the winner's data.
  - src_tag[wr_ptr] <= winner; wr_ptr <= wr_ptr + 1.
  - prio <= !winner, i.e. the other requester is preferred next. prio changes only on a push.
- No push: o_buf_wr_en = 0 and o_buf_wr_data = i_a_data. The data value is don't-care, but the mux is fixed.
- Read path:
  - o_buf_rd_addr = rd_ptr, o_rd_valid = !o_empty, o_rd_src = src_tag[rd_ptr].
  - Pop (o_rd_valid && i_rd_ready) sets rd_ptr <= rd_ptr + 1.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged. This is legal whenever 0 < count < DEPTH.
- Boundaries:
  - Full: both readies are low and no write occurs. A pop in the same cycle does not enable a push; there is no pass-through.
  - Empty: o_rd_valid = 0 and i_rd_ready is ignored.
  - Pointers wrap from 3 to 0.
  - Overflow and underflow are structurally impossible and are asserted in simulation.
- Flush:
  - wr_ptr, rd_ptr and count go to 0 and prio goes to 0; src_tag is unchanged.
  - Both readies are low and o_buf_wr_en = 0 during the flush cycle.
  - A same-cycle pop is discarded.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0, prio = 0, src_tag = 0.
  - Outputs: o_buf_wr_en = 0, o_rd_valid = 0, o_empty = 1, o_full = 0, o_count = 0, o_buf_rd_addr = 0, o_rd_src = 0.
- Reset asserted mid-operation clears state immediately, regardless of clock. Buffer contents are not cleared.

## Timing

- Push latency: a word accepted at edge N becomes head data visible on the consumer side after edge N.
  - If the FIFO was empty, o_rd_valid rises in cycle N+1.
  - o_buf_rd_addr already points to the entry written at edge N, so the data is valid in the same cycle.
- o_count, o_full and o_empty are registered-state decodes and change one cycle after the push/pop edge.
- Ready paths:
  - o_x_ready depends combinationally on i_a_valid, i_b_valid and i_flush.
  - No output depends combinationally on i_rd_ready.
- Throughput: one push and one pop per cycle sustained.

## Structure

- Package buffer_pkg holds:
  - DATA_W, DEPTH and ADDR_W defaults.
  - Source encoding constants SRC_A = 1'b0 and SRC_B = 1'b1.
- Sub-module rr_arb2 (two-requester round-robin arbiter):
  - Inputs: req[1:0], prio, advance.
  - Outputs: gnt[1:0] and next prio.
- Top level buffer_ctrl instantiates rr_arb2 and holds the pointers, count and tag array. The buffer itself is instantiated beside this block by the parent, not inside it.

## Test plan

- Reset, then A pushes 47'h1 and 47'h2 on back-to-back cycles with i_rd_ready = 0 → o_count = 2, wr_addr sequence 0,1, o_rd_valid rises the cycle after the first push, o_rd_src = 0.
- A and B both valid continuously for 4 cycles from reset → grants alternate A,B,A,B. Then o_full = 1, both readies are low, and tags read back 0,1,0,1.
- Fill to 4 with i_rd_ready = 1 and A valid → no push while full. After the pop, count = 3; the next cycle pushes and count stays 3.
- Stream 10 words from B with i_rd_ready = 1 → pointers wrap 3→0 twice, data and order are preserved, and o_count never exceeds 1 after warm-up.
- Flush asserted with count = 3 and a simultaneous pop and A push → next cycle count = 0, o_empty = 1, no write, and prio = A.
- Reset deasserted, then asserted asynchronously mid-stream between edges → o_rd_valid and o_buf_wr_en drop immediately and count = 0.
